i2c_target_regs: RTL

- I2C target (responder) for the bus driven by the team's I2C generator.
- Recognises one 7-bit address.
- Write transactions: accepts a 16-bit word as two bytes, MSB byte first, and presents it on a parallel port.
- Read transactions: returns a 16-bit word supplied by the host logic.
- Placement: on the peripheral side of the SDA/SCL pads, clocked by a system clock much faster than SCL.

---
 rtl/i2c_target_regs.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target that accepts and returns 16-bit words
// A single-address responder: two-byte writes land on RX_DATA, reads return TX_DATA MSB first.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  input  logic [15:0] TX_DATA,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        RD_STB,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronise; [2] is the history flop used for edge detection
  logic [2:0] scl_pipe;
  logic [2:0] sda_pipe;
  logic       scl_s, scl_prev, sda_s, sda_prev;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  always_ff @(posedge clk) begin
    if (RESET) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], SCL_IN};
      sda_pipe <= {sda_pipe[1:0], SDA_IN};
    end
  end

  assign scl_s    = scl_pipe[1];
  assign scl_prev = scl_pipe[2];
  assign sda_s    = sda_pipe[1];
  assign sda_prev = sda_pipe[2];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign start_ev = scl_s & sda_prev & ~sda_s;
  assign stop_ev  = scl_s & ~sda_prev & sda_s;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift_q, shift_n;
  logic [15:0] tx_sh, tx_sh_n;
  logic [15:0] hold, hold_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic        rnw, rnw_n;
  logic        rd_second, rd_second_n;
  logic        oe_n, out_n, busy_n;
  logic [15:0] rx_data_n;
  logic        rx_valid_n, rd_stb_n;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift_q   <= 8'h00;
      tx_sh     <= 16'h0000;
      hold      <= 16'h0000;
      byte_idx  <= 2'd0;
      rnw       <= 1'b0;
      rd_second <= 1'b0;
      SDA_OE    <= 1'b0;
      SDA_OUT   <= 1'b1;
      BUSY      <= 1'b0;
      RX_DATA   <= 16'h0000;
      RX_VALID  <= 1'b0;
      RD_STB    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_q   <= shift_n;
      tx_sh     <= tx_sh_n;
      hold      <= hold_n;
      byte_idx  <= byte_idx_n;
      rnw       <= rnw_n;
      rd_second <= rd_second_n;
      SDA_OE    <= oe_n;
      SDA_OUT   <= out_n;
      BUSY      <= busy_n;
      RX_DATA   <= rx_data_n;
      RX_VALID  <= rx_valid_n;
      RD_STB    <= rd_stb_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_q;
    tx_sh_n     = tx_sh;
    hold_n      = hold;
    byte_idx_n  = byte_idx;
    rnw_n       = rnw;
    rd_second_n = rd_second;
    oe_n        = SDA_OE;
    out_n       = SDA_OUT;
    busy_n      = BUSY;
    rx_data_n   = RX_DATA;
    rx_valid_n  = 1'b0;
    rd_stb_n    = 1'b0;

    // START outranks STOP and both override whatever byte is in flight
    if (start_ev) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      shift_n   = 8'h00;
      oe_n      = 1'b0;
      out_n     = 1'b1;
      busy_n    = 1'b0;
    end else if (stop_ev) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      out_n     = 1'b1;
      busy_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = {shift_q[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            rnw_n     = shift_q[0];
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_n = ADDR_ACK;
              oe_n    = 1'b1;
              out_n   = 1'b0;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT_STOP;
              oe_n    = 1'b0;
              out_n   = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rnw) begin
              state_n    = WR_BYTE;
              byte_idx_n = 2'd0;
              oe_n       = 1'b0;
              out_n      = 1'b1;
            end else begin
              state_n     = RD_BYTE;
              tx_sh_n     = {TX_DATA[14:0], 1'b0};
              rd_stb_n    = 1'b1;
              oe_n        = 1'b1;
              out_n       = TX_DATA[15];
              bit_cnt_n   = 4'd1;
              rd_second_n = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = {shift_q[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (byte_idx == 2'd0) begin
              hold_n[15:8] = shift_q;
              state_n      = WR_ACK;
              oe_n         = 1'b1;
              out_n        = 1'b0;
            end else if (byte_idx == 2'd1) begin
              hold_n[7:0] = shift_q;
              state_n     = WR_ACK;
              oe_n        = 1'b1;
              out_n       = 1'b0;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n = WR_BYTE;
            oe_n    = 1'b0;
            out_n   = 1'b1;
            if (byte_idx == 2'd0) begin
              byte_idx_n = 2'd1;
            end else begin
              rx_data_n  = hold;
              rx_valid_n = 1'b1;
              byte_idx_n = 2'd2;
            end
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n   = RD_ACK;
              bit_cnt_n = 4'd0;
              oe_n      = 1'b0;
              out_n     = 1'b1;
            end else begin
              oe_n      = 1'b1;
              out_n     = tx_sh[15];
              tx_sh_n   = {tx_sh[14:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s && !rd_second) begin
              state_n     = RD_BYTE;
              rd_second_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
